// File: rtl/array_output_fifo_if.sv
// Handshake bundle between the array output producer and the output FIFO.
// The master side drives the write ports and the consume/flush controls; the FIFO is the slave.
`timescale 1ns/1ps
interface array_output_fifo_if #(
  parameter int N_BITS          = 9,
  parameter int NUM_WRITE_PORTS = 4,
  parameter int COUNT_BITS      = 5
);
  logic [NUM_WRITE_PORTS-1:0]             in_valid;
  logic [NUM_WRITE_PORTS-1:0][31:0]       in_output;
  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0] in_row;
  logic [NUM_WRITE_PORTS-1:0][N_BITS-1:0] in_col;
  logic                                   in_ready;
  logic                                   flush;
  logic                                   out_valid;
  logic [31:0]                            out_output;
  logic [N_BITS-1:0]                      out_row;
  logic [N_BITS-1:0]                      out_col;
  logic                                   out_consume;
  logic [COUNT_BITS-1:0]                  count;
  logic                                   almost_full;
  logic                                   overflow;
  logic                                   idle;

  modport master (
    output in_valid, in_output, in_row, in_col, flush, out_consume,
    input  in_ready, out_valid, out_output, out_row, out_col,
           count, almost_full, overflow, idle
  );

  modport slave (
    input  in_valid, in_output, in_row, in_col, flush, out_consume,
    output in_ready, out_valid, out_output, out_row, out_col,
           count, almost_full, overflow, idle
  );
endinterface

// File: rtl/array_output_fifo.sv
// Multi-port write, single-port read circular FIFO collecting unquantized array outputs
// with their matrix coordinates; a whole write group is accepted or dropped atomically.
`timescale 1ns/1ps
module array_output_fifo #(
  parameter int MAX_N           = 512,
  parameter int N_BITS          = $clog2(MAX_N),
  parameter int NUM_WRITE_PORTS = 4,
  parameter int DEPTH           = 16,
  parameter int AFULL_LEVEL     = DEPTH - NUM_WRITE_PORTS,
  parameter int PTR_BITS        = $clog2(DEPTH),
  parameter int COUNT_BITS      = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               reset,
  array_output_fifo_if.slave bus
);

  typedef struct packed {
    logic [31:0]       value;
    logic [N_BITS-1:0] row;
    logic [N_BITS-1:0] col;
  } entry_t;

  entry_t                mem_r [DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr_r;
  logic [PTR_BITS-1:0]   rd_ptr_r;
  logic [COUNT_BITS-1:0] count_r;
  logic                  overflow_r;
  logic                  out_valid_r;
  logic                  almost_full_r;

  logic [COUNT_BITS-1:0] space_s;
  logic                  in_ready_s;
  logic                  any_valid_s;
  logic                  push_en_s;
  logic                  pop_en_s;
  logic [COUNT_BITS-1:0] push_cnt_s;
  logic [PTR_BITS-1:0]   slot_s [NUM_WRITE_PORTS];
  logic [COUNT_BITS-1:0] count_next_s;

  // Readiness depends only on registered occupancy, so no combinational path from the handshakes.
  always_comb begin
    space_s     = COUNT_BITS'(DEPTH) - count_r;
    in_ready_s  = (space_s >= COUNT_BITS'(NUM_WRITE_PORTS));
    any_valid_s = |bus.in_valid;
    push_en_s   = any_valid_s && in_ready_s && !bus.flush;
    pop_en_s    = (count_r != COUNT_BITS'(0)) && bus.out_consume && !bus.flush;
  end

  // Pack asserted ports into consecutive slots; a port's slot is wr_ptr plus the valid ports below it.
  always_comb begin
    push_cnt_s = COUNT_BITS'(0);
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      slot_s[p] = wr_ptr_r + PTR_BITS'(push_cnt_s);
      if (bus.in_valid[p]) begin
        push_cnt_s = push_cnt_s + COUNT_BITS'(1);
      end else begin
        push_cnt_s = push_cnt_s;
      end
    end
  end

  // Next occupancy; flush wins over any same-cycle push or pop.
  always_comb begin
    if (bus.flush) begin
      count_next_s = COUNT_BITS'(0);
    end else begin
      count_next_s = count_r
                   + (push_en_s ? push_cnt_s : COUNT_BITS'(0))
                   - (pop_en_s  ? COUNT_BITS'(1) : COUNT_BITS'(0));
    end
  end

  // Control state: pointers, occupancy, sticky overflow and the registered status flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r      <= PTR_BITS'(0);
      rd_ptr_r      <= PTR_BITS'(0);
      count_r       <= COUNT_BITS'(0);
      overflow_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
    end else begin
      count_r       <= count_next_s;
      out_valid_r   <= (count_next_s != COUNT_BITS'(0));
      almost_full_r <= (count_next_s >= COUNT_BITS'(AFULL_LEVEL));
      if (bus.flush) begin
        wr_ptr_r <= PTR_BITS'(0);
        rd_ptr_r <= PTR_BITS'(0);
      end else begin
        if (push_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_BITS'(push_cnt_s);
        end
        if (pop_en_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
        end
      end
      // A group arriving during a flush is discarded by the flush, not counted as a drop.
      if (any_valid_s && !in_ready_s && !bus.flush) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage is deliberately unreset; only the control state above is cleared.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (bus.in_valid[p]) begin
          mem_r[slot_s[p]] <= '{value: bus.in_output[p], row: bus.in_row[p], col: bus.in_col[p]};
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_output  = mem_r[rd_ptr_r].value;
  assign bus.out_row     = mem_r[rd_ptr_r].row;
  assign bus.out_col     = mem_r[rd_ptr_r].col;
  assign bus.count       = count_r;
  assign bus.almost_full = almost_full_r;
  assign bus.overflow    = overflow_r;
  assign bus.idle        = (count_r == COUNT_BITS'(0)) && !any_valid_s;

endmodule
